// File: rtl/snk_input_mapper_pkg.sv
// Shared bit maps, word type and combo state encoding for the SNK input mapper.
package snk_input_pkg;

  typedef logic [15:0] player_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    FIRED = 2'd2
  } combo_state_t;

  // HPS joystick word, active-high
  localparam int HPS_R       = 0;
  localparam int HPS_L       = 1;
  localparam int HPS_D       = 2;
  localparam int HPS_U       = 3;
  localparam int HPS_A       = 4;
  localparam int HPS_B       = 5;
  localparam int HPS_C       = 6;
  localparam int HPS_START   = 7;
  localparam int HPS_COIN    = 8;
  localparam int HPS_SERVICE = 9;
  localparam int HPS_PAUSE   = 10;

  // DB15 SNAC word, active-high
  localparam int DB_R      = 0;
  localparam int DB_L      = 1;
  localparam int DB_D      = 2;
  localparam int DB_U      = 3;
  localparam int DB_A      = 4;
  localparam int DB_B      = 5;
  localparam int DB_C      = 6;
  localparam int DB_START  = 10;
  localparam int DB_SELECT = 11;

  // PLAYERn word, active-low
  localparam int OUT_COIN    = 0;
  localparam int OUT_START   = 1;
  localparam int OUT_SHOT    = 2;
  localparam int OUT_MISSILE = 3;
  localparam int OUT_ARMOR   = 4;
  localparam int OUT_SERVICE = 9;
  localparam int OUT_LEFT    = 10;
  localparam int OUT_RIGHT   = 11;
  localparam int OUT_DOWN    = 12;
  localparam int OUT_UP      = 13;

endpackage

// File: rtl/snk_input_mapper_if.sv
// Source and player-word bundle for snk_input_mapper.
// Defining SNK_INPUT_AUTOFIRE_EN adds the per-player autofire_ena lines.
interface snk_input_mapper_if #(
  parameter int NUM_PLAYERS = 2
);
  logic [NUM_PLAYERS*16-1:0] joy_hps;
  logic [NUM_PLAYERS*16-1:0] joy_db15;
  logic [NUM_PLAYERS-1:0]    snac_sel;
  logic [NUM_PLAYERS*16-1:0] player_out;
  logic                      pause_req;

`ifdef SNK_INPUT_AUTOFIRE_EN
  logic [NUM_PLAYERS-1:0]    autofire_ena;

  modport master (output joy_hps, joy_db15, snac_sel, autofire_ena,
                  input  player_out, pause_req);
  modport slave  (input  joy_hps, joy_db15, snac_sel, autofire_ena,
                  output player_out, pause_req);
`else
  modport master (output joy_hps, joy_db15, snac_sel,
                  input  player_out, pause_req);
  modport slave  (input  joy_hps, joy_db15, snac_sel,
                  output player_out, pause_req);
`endif
endinterface

// File: rtl/snk_input_mapper_player.sv
// One player channel: source mux, coin stretcher, pause/service combo FSMs.
// SNK_INPUT_AUTOFIRE_EN adds an autofire modulator on the shot button.
//
// state | meaning
// IDLE  | combo not fully pressed
// COUNT | combo held, counting towards COMBO_HOLD_CYC
// FIRED | combo fired, waits for full release
module snk_input_player
  import snk_input_pkg::*;
#(
  parameter int COIN_PULSE_CYC = 536000,
  parameter int COMBO_HOLD_CYC = 2680000,
  parameter int CNT_W          = 22
`ifdef SNK_INPUT_AUTOFIRE_EN
  , parameter int AUTOFIRE_HALF_CYC = 893333
`endif
) (
  input  logic         i_clk,
  input  logic         RESETn,
  input  player_word_t joy_hps,
  input  player_word_t joy_db15,
  input  logic         snac_sel,
`ifdef SNK_INPUT_AUTOFIRE_EN
  input  logic         autofire_ena,
`endif
  output player_word_t player_out,
  output logic         pause_pulse
);
  localparam logic [CNT_W-1:0] COIN_LOAD = CNT_W'(COIN_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(COMBO_HOLD_CYC - 1);
  localparam int PAUSE   = 0;
  localparam int SERVICE = 1;

  player_word_t     hps_q, db_q, word_q;
  logic             sel_q, sel_prev, src_switch;
  logic             up, down, left, right, shot_raw, shot, missile, armor, start, coin_raw;
  logic [1:0]       combo_all, combo_any;
  logic             coin_prev, coin_low;
  logic [CNT_W-1:0] coin_cnt;
  combo_state_t     combo_st  [2];
  logic [CNT_W-1:0] combo_cnt [2];
  logic             unused_bits;

  assign unused_bits = ^{hps_q[15:11], db_q[15:12], db_q[9:7]};
  assign src_switch  = sel_q ^ sel_prev;
  assign coin_low    = coin_raw | (coin_cnt != '0);
  assign player_out  = word_q;

  // On DB15, Select doubles as coin and combo modifier, so it masks A/B.
  always_comb begin
    if (sel_q) begin
      up        = db_q[DB_U];
      down      = db_q[DB_D];
      left      = db_q[DB_L];
      right     = db_q[DB_R];
      shot_raw  = db_q[DB_A] & ~db_q[DB_SELECT];
      missile   = db_q[DB_B] & ~db_q[DB_SELECT];
      armor     = db_q[DB_C];
      start     = db_q[DB_START];
      coin_raw  = db_q[DB_SELECT];
      combo_all = {db_q[DB_SELECT] & db_q[DB_B], db_q[DB_SELECT] & db_q[DB_A]};
      combo_any = {db_q[DB_SELECT] | db_q[DB_B], db_q[DB_SELECT] | db_q[DB_A]};
    end else begin
      up        = hps_q[HPS_U];
      down      = hps_q[HPS_D];
      left      = hps_q[HPS_L];
      right     = hps_q[HPS_R];
      shot_raw  = hps_q[HPS_A];
      missile   = hps_q[HPS_B];
      armor     = hps_q[HPS_C];
      start     = hps_q[HPS_START];
      coin_raw  = hps_q[HPS_COIN];
      combo_all = {hps_q[HPS_SERVICE], hps_q[HPS_PAUSE]};
      combo_any = {hps_q[HPS_SERVICE], hps_q[HPS_PAUSE]};
    end
  end

`ifdef SNK_INPUT_AUTOFIRE_EN
  localparam logic [CNT_W-1:0] AF_LAST = CNT_W'(AUTOFIRE_HALF_CYC - 1);
  logic [CNT_W-1:0] af_cnt;
  logic             af_off;

  always_ff @(posedge i_clk or negedge RESETn) begin
    if (!RESETn) begin
      af_cnt <= '0;
      af_off <= 1'b0;
    end else if (!shot_raw || !autofire_ena) begin
      af_cnt <= '0;
      af_off <= 1'b0;
    end else if (af_cnt == AF_LAST) begin
      af_cnt <= '0;
      af_off <= ~af_off;
    end else begin
      af_cnt <= af_cnt + 1'b1;
    end
  end

  assign shot = shot_raw & ~(autofire_ena & af_off);
`else
  assign shot = shot_raw;
`endif

  always_ff @(posedge i_clk or negedge RESETn) begin
    if (!RESETn) begin
      hps_q       <= '0;
      db_q        <= '0;
      sel_q       <= 1'b0;
      sel_prev    <= 1'b0;
      coin_prev   <= 1'b0;
      coin_cnt    <= '0;
      pause_pulse <= 1'b0;
      word_q      <= '1;
      for (int i = 0; i < 2; i++) begin
        combo_st[i]  <= IDLE;
        combo_cnt[i] <= '0;
      end
    end else begin
      hps_q       <= joy_hps;
      db_q        <= joy_db15;
      sel_q       <= snac_sel;
      sel_prev    <= sel_q;
      coin_prev   <= coin_raw;
      pause_pulse <= 1'b0;
      if (src_switch) begin
        coin_cnt <= '0;
        word_q   <= '1;
        for (int i = 0; i < 2; i++) combo_st[i] <= IDLE;
      end else begin
        if (coin_raw && !coin_prev) coin_cnt <= COIN_LOAD;
        else if (coin_cnt != '0)    coin_cnt <= coin_cnt - 1'b1;
        for (int i = 0; i < 2; i++) begin
          case (combo_st[i])
            IDLE: if (combo_all[i]) begin
              combo_st[i]  <= COUNT;
              combo_cnt[i] <= '0;
            end
            COUNT: if (!combo_all[i]) begin
              combo_st[i] <= IDLE;
            end else if (combo_cnt[i] == HOLD_LAST) begin
              combo_st[i] <= FIRED;
              if (i == PAUSE) pause_pulse <= 1'b1;
            end else begin
              combo_cnt[i] <= combo_cnt[i] + 1'b1;
            end
            FIRED: if (!combo_any[i]) combo_st[i] <= IDLE;
            default: combo_st[i] <= IDLE;
          endcase
        end
        word_q <= ~{2'b00, up, down, right, left, combo_st[SERVICE] == FIRED,
                    4'b0000, armor, missile, shot, start, coin_low};
      end
    end
  end

endmodule

// File: rtl/snk_input_mapper.sv
// Per-player input front end for SNK TripleZ80: one snk_input_player per channel.
// SNK_INPUT_AUTOFIRE_EN enables the optional shot autofire (AUTOFIRE_HALF_CYC).
module snk_input_mapper
  import snk_input_pkg::*;
#(
  parameter int NUM_PLAYERS    = 2,
  parameter int COIN_PULSE_CYC = 536000,
  parameter int COMBO_HOLD_CYC = 2680000,
  parameter int CNT_W          = 22
`ifdef SNK_INPUT_AUTOFIRE_EN
  , parameter int AUTOFIRE_HALF_CYC = 893333
`endif
) (
  input logic               i_clk,
  input logic               RESETn,
  snk_input_mapper_if.slave bus
);
  logic [NUM_PLAYERS*16-1:0] words;
  logic [NUM_PLAYERS-1:0]    pause_vec;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    snk_input_player #(
      .COIN_PULSE_CYC   (COIN_PULSE_CYC),
      .COMBO_HOLD_CYC   (COMBO_HOLD_CYC),
      .CNT_W            (CNT_W)
`ifdef SNK_INPUT_AUTOFIRE_EN
      , .AUTOFIRE_HALF_CYC(AUTOFIRE_HALF_CYC)
`endif
    ) u_player (
      .i_clk       (i_clk),
      .RESETn      (RESETn),
      .joy_hps     (bus.joy_hps[p*16 +: 16]),
      .joy_db15    (bus.joy_db15[p*16 +: 16]),
      .snac_sel    (bus.snac_sel[p]),
`ifdef SNK_INPUT_AUTOFIRE_EN
      .autofire_ena(bus.autofire_ena[p]),
`endif
      .player_out  (words[p*16 +: 16]),
      .pause_pulse (pause_vec[p])
    );
  end

  // Simultaneous fires land in the same cycle, so the OR stays one pulse.
  assign bus.player_out = words;
  assign bus.pause_req  = |pause_vec;

endmodule

// File: tb/tb_snk_input_mapper.sv
// Directed bench for snk_input_mapper: vector table plus multi-cycle sequences.
module tb_snk_input_mapper;

  localparam int NP = 2;

  logic i_clk  = 1'b0;
  logic RESETn = 1'b0;
  always #5 i_clk = ~i_clk;

  snk_input_mapper_if #(.NUM_PLAYERS(NP)) bus ();

  snk_input_mapper #(
    .NUM_PLAYERS   (NP),
    .COIN_PULSE_CYC(8),
    .COMBO_HOLD_CYC(16),
    .CNT_W         (22)
  ) dut (
    .i_clk (i_clk),
    .RESETn(RESETn),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] h0, h1, d0, d1;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(input logic [15:0] h0, h1, d0, d1);
    bus.joy_hps  = {h1, h0};
    bus.joy_db15 = {d1, d0};
  endtask

  task automatic settle(input logic [1:0] sel);
    bus.snac_sel = sel;
    drive(16'h0, 16'h0, 16'h0, 16'h0);
    idle(4);
  endtask

  // Coin on P1 HPS held for 'hold' edges; low window must start one sample
  // after the source is registered and last max(hold, 8) cycles.
  task automatic coin_run(input int hold, input int exp_len);
    int first = -1, last = -1, lows = 0;
    settle(2'b00);
    bus.joy_hps[8] = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (bus.player_out[0] == 1'b0) begin
        if (first < 0) first = k;
        last = k;
        lows++;
      end
      if (k == hold - 1) bus.joy_hps[8] = 1'b0;
    end
    chk("coin first low", first, 1);
    chk("coin low length", lows, exp_len);
    chk("coin last low", last, exp_len);
  endtask

  // The FSM enters COUNT one edge after the source register, so the pulse
  // lands 16 cycles after that: sample index 17.
  task automatic pause_run(input string name, input logic [1:0] sel,
                           input logic [15:0] h0, h1, d0, d1,
                           input int hold, input int exp_pulses);
    int pulses = 0, idx = -1;
    logic shot_low = 1'b0;
    settle(sel);
    drive(h0, h1, d0, d1);
    for (int k = 0; k < 45; k++) begin
      tick();
      if (bus.pause_req) begin
        pulses++;
        idx = k;
      end
      if (bus.player_out[2] == 1'b0 || bus.player_out[18] == 1'b0) shot_low = 1'b1;
      if (k == hold - 1) drive(16'h0, 16'h0, 16'h0, 16'h0);
    end
    chk({name, " pulses"}, pulses, exp_pulses);
    if (exp_pulses > 0) chk({name, " pulse index"}, idx, 17);
    chk({name, " shot masked"}, {31'b0, shot_low}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] w [25];
    int svc_seen, ffff_cnt, lows, pulses;

    vecs[0]  = '{2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 32'hFFFF_FFFF};
    vecs[1]  = '{2'b00, 16'h0008, 16'h0000, 16'h0000, 16'h0000, 32'hFFFF_DFFF};
    vecs[2]  = '{2'b00, 16'h0011, 16'h0000, 16'h0000, 16'h0000, 32'hFFFF_F7FB};
    vecs[3]  = '{2'b00, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 32'hFFFB_FFFF};
    vecs[4]  = '{2'b00, 16'h000C, 16'h0000, 16'h0000, 16'h0000, 32'hFFFF_CFFF};
    vecs[5]  = '{2'b00, 16'h0000, 16'h0003, 16'h0000, 16'h0000, 32'hF3FF_FFFF};
    vecs[6]  = '{2'b00, 16'h00E0, 16'h0000, 16'h0000, 16'h0000, 32'hFFFF_FFE5};
    vecs[7]  = '{2'b00, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 32'hFFFF_FFFE};
    vecs[8]  = '{2'b00, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 32'hFFFE_FFFF};
    vecs[9]  = '{2'b01, 16'h0000, 16'h0000, 16'h0414, 16'h0000, 32'hFFFF_EFF9};
    vecs[10] = '{2'b01, 16'h0000, 16'h0000, 16'h0830, 16'h0000, 32'hFFFF_FFFE};
    vecs[11] = '{2'b10, 16'h0080, 16'h0008, 16'h0000, 16'h0042, 32'hFBEF_FFFD};
    vecs[12] = '{2'b11, 16'h0010, 16'h0010, 16'h0009, 16'h0400, 32'hFFFD_D7FF};
    vecs[13] = '{2'b00, 16'h0000, 16'h0000, 16'h0FFF, 16'h0FFF, 32'hFFFF_FFFF};

    bus.snac_sel = 2'b00;
    drive(16'h0, 16'h0, 16'h0, 16'h0);
    RESETn = 1'b0;
    idle(3);
    chk("reset out", bus.player_out, 32'hFFFF_FFFF);
    chk("reset pause", {31'b0, bus.pause_req}, 0);
    RESETn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("post-reset out", bus.player_out, 32'hFFFF_FFFF);
      chk("post-reset pause", {31'b0, bus.pause_req}, 0);
    end

    for (int v = 0; v < 14; v++) begin
      settle(vecs[v].sel);
      drive(vecs[v].h0, vecs[v].h1, vecs[v].d0, vecs[v].d1);
      tick();
      chk($sformatf("vec%0d before latency", v), bus.player_out, 32'hFFFF_FFFF);
      tick();
      chk($sformatf("vec%0d word", v), bus.player_out, vecs[v].exp);
      chk($sformatf("vec%0d pause", v), {31'b0, bus.pause_req}, 0);
      drive(16'h0, 16'h0, 16'h0, 16'h0);
      idle(12);
    end

    coin_run(1, 8);
    coin_run(20, 20);

    pause_run("db15 p1 pause 30", 2'b01, 16'h0, 16'h0, 16'h0810, 16'h0, 30, 1);
    pause_run("db15 p1 pause 10", 2'b01, 16'h0, 16'h0, 16'h0810, 16'h0, 10, 0);
    pause_run("db15 p2 pause 30", 2'b10, 16'h0, 16'h0, 16'h0, 16'h0810, 30, 1);
    pause_run("hps both pause", 2'b00, 16'h0400, 16'h0400, 16'h0, 16'h0, 30, 1);

    // HPS service button through the combo FSM
    settle(2'b00);
    drive(16'h0200, 16'h0, 16'h0, 16'h0);
    svc_seen = 0;
    for (int k = 0; k < 45; k++) begin
      tick();
      if (k < 16 && bus.player_out[9] == 1'b0) svc_seen = 99;
      if (k >= 16 && bus.player_out[9] == 1'b0 && svc_seen != 99) svc_seen = 1;
      if (k == 29) drive(16'h0, 16'h0, 16'h0, 16'h0);
    end
    chk("hps service asserted after hold", svc_seen, 1);
    chk("hps service released", {31'b0, bus.player_out[9]}, 1);

    // Source switch while Select+B is held on DB15, HPS Up held in background
    settle(2'b01);
    drive(16'h0008, 16'h0, 16'h0820, 16'h0);
    svc_seen = 0;
    ffff_cnt = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      w[k] = bus.player_out[15:0];
      if (bus.player_out[9] == 1'b0) svc_seen = 1;
      if (k >= 10 && bus.player_out[15:0] == 16'hFFFF) ffff_cnt++;
      if (k == 9) bus.snac_sel[0] = 1'b0;
    end
    chk("switch held select word", w[5], 16'hFFFE);
    chk("switch last db15 word", w[10], 16'hFFFE);
    chk("switch forced word", w[11], 16'hFFFF);
    chk("switch hps word", w[12], 16'hDFFF);
    chk("switch forced cycles", ffff_cnt, 1);
    chk("switch no service", svc_seen, 0);

    // Async reset in cycle 3 of a coin pulse
    settle(2'b00);
    bus.joy_hps[8] = 1'b1;
    tick();
    bus.joy_hps[8] = 1'b0;
    idle(3);
    chk("coin low before reset", bus.player_out, 32'hFFFF_FFFE);
    #2;
    RESETn = 1'b0;
    #1;
    chk("async reset out", bus.player_out, 32'hFFFF_FFFF);
    chk("async reset pause", {31'b0, bus.pause_req}, 0);
    idle(2);
    RESETn = 1'b1;
    lows = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.player_out != 32'hFFFF_FFFF) lows++;
    end
    chk("coin cleared by reset", lows, 0);

    // Reset in the middle of a pause count must not produce a pulse
    settle(2'b00);
    drive(16'h0400, 16'h0, 16'h0, 16'h0);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.pause_req) pulses++;
    end
    RESETn = 1'b0;
    drive(16'h0, 16'h0, 16'h0, 16'h0);
    idle(2);
    RESETn = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (bus.pause_req) pulses++;
    end
    chk("reset mid-count pulses", pulses, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
